// File: rtl/winograd_result_accumulator.sv
// Accumulates 6x6 partial result tiles per output address across input channels and
// queues saturated, completed tiles in a small shift-register FIFO for the output writer.
module winograd_result_accumulator #(
   parameter int ADDR_DEPTH     = 256,
   parameter int ACC_W          = 18,
   parameter int OUT_FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [4:0]         cfg_id_num_i,
   input  logic               cfg_size_type_i,
   input  logic               clear_i,
   input  logic signed [11:0] result_tile_i [0:5][0:5],
   input  logic [7:0]         result_address_i,
   input  logic               result_valid_i,
   output logic               result_ready_o,
   output logic signed [11:0] out_tile_o [0:5][0:5],
   output logic [7:0]         out_address_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               overflow_o,
   output logic               busy_o
);

   localparam int TD      = 6;
   localparam int SMALL_D = 4;
   localparam int FD      = OUT_FIFO_DEPTH;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [11:0]      pix_t;

   localparam acc_t SAT_MAX  = {{(ACC_W-11){1'b0}}, 11'h7FF};
   localparam acc_t SAT_MIN  = {{(ACC_W-11){1'b1}}, 11'h000};
   localparam acc_t ACC_ZERO = {ACC_W{1'b0}};

   function automatic pix_t sat12(input acc_t v);
      pix_t r;
      if (v > SAT_MAX) begin
         r = 12'sh7FF;
      end else if (v < SAT_MIN) begin
         r = 12'sh800;
      end else begin
         r = pix_t'(v[11:0]);
      end
      return r;
   endfunction

   acc_t       acc_q       [ADDR_DEPTH][TD][TD];
   logic [4:0] cnt_q       [ADDR_DEPTH];
   pix_t       fifo_tile_q [FD][TD][TD];
   pix_t       fifo_tile_d [FD][TD][TD];
   logic [7:0] fifo_addr_q [FD];
   logic [7:0] fifo_addr_d [FD];
   logic [FD-1:0] fifo_vld_q, fifo_vld_d;
   logic       overflow_q;

   acc_t       new_sum_s   [TD][TD];
   pix_t       push_tile_s [TD][TD];
   logic [4:0] old_cnt_s, new_cnt_s, id_lim_s;
   logic       addr_ok_s, accept_s, complete_s, push_s, pop_s, busy_s;
   int         wr_idx_s;

   assign addr_ok_s      = (32'(result_address_i) < 32'(ADDR_DEPTH));
   assign result_ready_o = ~fifo_vld_q[FD-1];
   assign accept_s       = result_valid_i & result_ready_o & addr_ok_s & ~clear_i;
   assign old_cnt_s      = cnt_q[result_address_i];
   assign new_cnt_s      = old_cnt_s + 5'd1;
   assign id_lim_s       = (cfg_id_num_i == 5'd0) ? 5'd1 : cfg_id_num_i;
   assign complete_s     = (new_cnt_s >= id_lim_s);
   assign push_s         = accept_s & complete_s;
   assign pop_s          = fifo_vld_q[0] & out_ready_i;

   // A slot whose count is zero reads as an all-zero accumulator, so acc_q never needs clearing.
   always_comb begin
      for (int i = 0; i < TD; i++) begin
         for (int j = 0; j < TD; j++) begin
            new_sum_s[i][j] = ((old_cnt_s == 5'd0) ? ACC_ZERO : acc_q[result_address_i][i][j])
                              + acc_t'(result_tile_i[i][j]);
            push_tile_s[i][j] = (cfg_size_type_i && (i >= SMALL_D || j >= SMALL_D))
                              ? 12'sd0 : sat12(new_sum_s[i][j]);
         end
      end
   end

   // Output FIFO next state: entry 0 is the head, entries above the fill level stay zero.
   always_comb begin
      wr_idx_s = 0;
      for (int k = 0; k < FD; k++) begin
         wr_idx_s = wr_idx_s + int'(fifo_vld_q[k]);
      end
      wr_idx_s = wr_idx_s - int'(pop_s);
      for (int k = 0; k < FD - 1; k++) begin
         fifo_vld_d[k]  = pop_s ? fifo_vld_q[k+1]  : fifo_vld_q[k];
         fifo_addr_d[k] = pop_s ? fifo_addr_q[k+1] : fifo_addr_q[k];
         for (int i = 0; i < TD; i++) begin
            for (int j = 0; j < TD; j++) begin
               fifo_tile_d[k][i][j] = pop_s ? fifo_tile_q[k+1][i][j] : fifo_tile_q[k][i][j];
            end
         end
      end
      fifo_vld_d[FD-1]  = pop_s ? 1'b0 : fifo_vld_q[FD-1];
      fifo_addr_d[FD-1] = pop_s ? 8'd0 : fifo_addr_q[FD-1];
      for (int i = 0; i < TD; i++) begin
         for (int j = 0; j < TD; j++) begin
            fifo_tile_d[FD-1][i][j] = pop_s ? 12'sd0 : fifo_tile_q[FD-1][i][j];
         end
      end
      for (int k = 0; k < FD; k++) begin
         fifo_vld_d[k]  = (push_s && k == wr_idx_s) ? 1'b1 : fifo_vld_d[k];
         fifo_addr_d[k] = (push_s && k == wr_idx_s) ? result_address_i : fifo_addr_d[k];
         for (int i = 0; i < TD; i++) begin
            for (int j = 0; j < TD; j++) begin
               fifo_tile_d[k][i][j] = (push_s && k == wr_idx_s) ? push_tile_s[i][j]
                                                                 : fifo_tile_d[k][i][j];
            end
         end
      end
   end

   // Busy while any slot holds a partial sum or a completed tile is waiting.
   always_comb begin
      busy_s = fifo_vld_q[0];
      for (int a = 0; a < ADDR_DEPTH; a++) begin
         busy_s = busy_s | (cnt_q[a] != 5'd0);
      end
   end

   // Accumulator data write-back; validity is carried by cnt_q.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         for (int i = 0; i < TD; i++) begin
            for (int j = 0; j < TD; j++) begin
               acc_q[result_address_i][i][j] <= new_sum_s[i][j];
            end
         end
      end
   end

   // Slot counts, output FIFO and sticky overflow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int a = 0; a < ADDR_DEPTH; a++) begin
            cnt_q[a] <= 5'd0;
         end
         fifo_vld_q <= '0;
         for (int k = 0; k < FD; k++) begin
            fifo_addr_q[k] <= 8'd0;
            for (int i = 0; i < TD; i++) begin
               for (int j = 0; j < TD; j++) begin
                  fifo_tile_q[k][i][j] <= 12'sd0;
               end
            end
         end
         overflow_q <= 1'b0;
      end else begin
         if (clear_i) begin
            for (int a = 0; a < ADDR_DEPTH; a++) begin
               cnt_q[a] <= 5'd0;
            end
         end else if (accept_s) begin
            cnt_q[result_address_i] <= complete_s ? 5'd0 : new_cnt_s;
         end
         fifo_vld_q  <= fifo_vld_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_tile_q <= fifo_tile_d;
         overflow_q  <= overflow_q | (result_valid_i & (~result_ready_o | ~addr_ok_s));
      end
   end

   assign out_valid_o   = fifo_vld_q[0];
   assign out_address_o = fifo_addr_q[0];
   assign out_tile_o    = fifo_tile_q[0];
   assign overflow_o    = overflow_q;
   assign busy_o        = busy_s;

endmodule

// File: tb/tb_winograd_result_accumulator.sv
// Bench for winograd_result_accumulator: reference model of slot sums and the output queue,
// directed vectors from a table, hand-written corner sequences and randomized traffic.
module tb_winograd_result_accumulator;

   localparam int DEPTH = 256;
   localparam int FD    = 4;

   logic               clk = 1'b0;
   logic               reset_s;
   logic [4:0]         cfg_id_num_s;
   logic               cfg_size_s;
   logic               clear_s;
   logic signed [11:0] tile_s [0:5][0:5];
   logic [7:0]         addr_s;
   logic               valid_s;
   logic               result_ready_s;
   logic signed [11:0] out_tile_s [0:5][0:5];
   logic [7:0]         out_address_s;
   logic               out_valid_s;
   logic               out_ready_s;
   logic               overflow_s;
   logic               busy_s;

   winograd_result_accumulator dut (
      .clk              (clk),
      .reset            (reset_s),
      .cfg_id_num_i     (cfg_id_num_s),
      .cfg_size_type_i  (cfg_size_s),
      .clear_i          (clear_s),
      .result_tile_i    (tile_s),
      .result_address_i (addr_s),
      .result_valid_i   (valid_s),
      .result_ready_o   (result_ready_s),
      .out_tile_o       (out_tile_s),
      .out_address_o    (out_address_s),
      .out_valid_o      (out_valid_s),
      .out_ready_i      (out_ready_s),
      .overflow_o       (overflow_s),
      .busy_o           (busy_s)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int t [6][6]; } ent_t;
   typedef struct { int a; int b; int addr; bit size; int exp_c; int exp_e; } vec_t;

   ent_t mq [$];
   int   m_sum [DEPTH][6][6];
   int   m_cnt [DEPTH];
   bit   m_ovf;
   int   checks = 0;
   int   errors = 0;

   function automatic int clamp12(input int v);
      return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < DEPTH; a++) begin
         m_cnt[a] = 0;
         for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) m_sum[a][i][j] = 0;
      end
      mq.delete();
      m_ovf = 1'b0;
   endtask

   task automatic check_outputs();
      int ea, bi, bj;
      int et [6][6];
      bit busy_exp;
      ea = 0; bi = 0; bj = 0;
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) et[i][j] = 0;
      if (mq.size() > 0) begin
         ea = mq[0].addr;
         et = mq[0].t;
      end
      busy_exp = (mq.size() > 0);
      for (int a = 0; a < DEPTH; a++) if (m_cnt[a] != 0) busy_exp = 1'b1;
      chk("out_valid", int'(out_valid_s), int'(mq.size() > 0));
      chk("result_ready", int'(result_ready_s), int'(mq.size() < FD));
      chk("overflow", int'(overflow_s), int'(m_ovf));
      chk("busy", int'(busy_s), int'(busy_exp));
      chk("out_address", int'(out_address_s), ea);
      for (int i = 5; i >= 0; i--)
         for (int j = 5; j >= 0; j--)
            if (int'(out_tile_s[i][j]) != et[i][j]) begin bi = i; bj = j; end
      chk("out_tile", int'(out_tile_s[bi][bj]), et[bi][bj]);
   endtask

   task automatic model_update();
      bit   ready;
      int   lim, a;
      ent_t e;
      if (!reset_s) begin
         model_reset();
      end else begin
         ready = (mq.size() < FD);
         lim   = (cfg_id_num_s == 5'd0) ? 1 : int'(cfg_id_num_s);
         if (valid_s && !ready) m_ovf = 1'b1;
         if (out_ready_s && mq.size() > 0) void'(mq.pop_front());
         if (clear_s) begin
            for (int k = 0; k < DEPTH; k++) m_cnt[k] = 0;
            for (int k = 0; k < DEPTH; k++)
               for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) m_sum[k][i][j] = 0;
         end else if (valid_s && ready) begin
            a = int'(addr_s);
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 6; j++) m_sum[a][i][j] += int'(tile_s[i][j]);
            m_cnt[a]++;
            if (m_cnt[a] >= lim) begin
               e.addr = a;
               for (int i = 0; i < 6; i++)
                  for (int j = 0; j < 6; j++) begin
                     e.t[i][j] = (cfg_size_s && (i > 3 || j > 3)) ? 0 : clamp12(m_sum[a][i][j]);
                     m_sum[a][i][j] = 0;
                  end
               m_cnt[a] = 0;
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tile(input int v);
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) tile_s[i][j] = 12'(v);
   endtask

   task automatic send(input int a, input int v);
      valid_s = 1'b1;
      addr_s  = 8'(a);
      set_tile(v);
      step();
      valid_s = 1'b0;
   endtask

   task automatic idle();
      valid_s = 1'b0;
      step();
   endtask

   task automatic do_reset();
      reset_s = 1'b0;
      step();
      reset_s = 1'b1;
   endtask

   vec_t vecs [8];
   int   nbad;

   initial begin
      vecs[0] = '{100,   200,   5,   1'b0, 300,   300};
      vecs[1] = '{2000,  2000,  7,   1'b0, 2047,  2047};
      vecs[2] = '{-2000, -2000, 7,   1'b0, -2048, -2048};
      vecs[3] = '{9,     0,     0,   1'b1, 9,     0};
      vecs[4] = '{-5,    3,     255, 1'b1, -2,    0};
      vecs[5] = '{2047,  1,     128, 1'b0, 2047,  2047};
      vecs[6] = '{-2048, -1,    3,   1'b0, -2048, -2048};
      vecs[7] = '{1000,  -1500, 200, 1'b1, -500,  0};

      reset_s = 1'b0; cfg_id_num_s = 5'd1; cfg_size_s = 1'b0; clear_s = 1'b0;
      valid_s = 1'b0; addr_s = 8'd0; out_ready_s = 1'b0;
      set_tile(0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset_s = 1'b1;
      chk("reset_out_valid", int'(out_valid_s), 0);
      chk("reset_ready", int'(result_ready_s), 1);
      chk("reset_busy", int'(busy_s), 0);
      chk("reset_out_address", int'(out_address_s), 0);

      // Three contributions summing to 250 at address 5.
      cfg_id_num_s = 5'd3; out_ready_s = 1'b1;
      send(5, 100); send(5, 200);
      chk("seq1_no_early_valid", int'(out_valid_s), 0);
      send(5, -50);
      chk("seq1_valid", int'(out_valid_s), 1);
      chk("seq1_addr", int'(out_address_s), 5);
      nbad = 0;
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) if (out_tile_s[i][j] != 12'sd250) nbad++;
      chk("seq1_all_250_bad_count", nbad, 0);
      idle();
      chk("seq1_busy_cleared", int'(busy_s), 0);

      // Table: two contributions per address, saturation and 4x4 masking.
      cfg_id_num_s = 5'd2;
      for (int v = 0; v < 8; v++) begin
         out_ready_s = 1'b0;
         cfg_size_s  = vecs[v].size;
         send(vecs[v].addr, vecs[v].a);
         send(vecs[v].addr, vecs[v].b);
         chk("vec_valid", int'(out_valid_s), 1);
         chk("vec_addr", int'(out_address_s), vecs[v].addr);
         chk("vec_elem00", int'(out_tile_s[0][0]), vecs[v].exp_c);
         chk("vec_elem55", int'(out_tile_s[5][5]), vecs[v].exp_e);
         out_ready_s = 1'b1;
         idle();
      end
      cfg_size_s = 1'b0;

      // Fill the FIFO, drop the fifth tile, then drain in order.
      cfg_id_num_s = 5'd1; out_ready_s = 1'b0;
      for (int k = 0; k < 4; k++) send(k, k + 1);
      chk("full_ready_low", int'(result_ready_s), 0);
      send(4, 5);
      chk("full_overflow", int'(overflow_s), 1);
      for (int k = 0; k < 4; k++) begin
         chk("drain_addr", int'(out_address_s), k);
         chk("drain_value", int'(out_tile_s[3][2]), k + 1);
         out_ready_s = 1'b1;
         idle();
      end
      chk("drain_empty", int'(out_valid_s), 0);

      // clear_i discards partial sums and wins over a same-cycle tile.
      cfg_id_num_s = 5'd4;
      send(9, 5); send(9, 5);
      clear_s = 1'b1; send(9, 5); clear_s = 1'b0;
      chk("clear_no_output", int'(out_valid_s), 0);
      chk("clear_not_busy", int'(busy_s), 0);
      for (int k = 0; k < 4; k++) send(9, 1);
      chk("clear_then_four", int'(out_tile_s[2][2]), 4);
      idle();

      // Interleaved addresses, then reset in the middle of accumulation.
      cfg_id_num_s = 5'd2;
      send(1, 10); send(2, 20); send(1, 30);
      chk("ilv_addr1", int'(out_address_s), 1);
      chk("ilv_val1", int'(out_tile_s[4][1]), 40);
      send(2, 40);
      chk("ilv_addr2", int'(out_address_s), 2);
      chk("ilv_val2", int'(out_tile_s[1][4]), 60);
      idle();
      send(3, 7);
      do_reset();
      chk("rst_out_valid", int'(out_valid_s), 0);
      chk("rst_overflow", int'(overflow_s), 0);
      chk("rst_busy", int'(busy_s), 0);
      send(3, 7);
      chk("rst_partial_discarded", int'(out_valid_s), 0);
      chk("rst_busy_after_tile", int'(busy_s), 1);

      // Randomized traffic against the model.
      for (int seg = 0; seg < 3; seg++) begin
         cfg_id_num_s = 5'($urandom_range(0, 16));
         cfg_size_s   = 1'($urandom_range(0, 1));
         do_reset();
         for (int n = 0; n < 200; n++) begin
            valid_s     = ($urandom_range(0, 3) != 0);
            addr_s      = 8'($urandom_range(0, 5));
            clear_s     = ($urandom_range(0, 39) == 0);
            out_ready_s = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 6; j++) tile_s[i][j] = 12'($urandom_range(0, 4095));
            step();
         end
         valid_s = 1'b0; clear_s = 1'b0; out_ready_s = 1'b1;
         repeat (6) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
